// File: rtl/fir_frame_collector.sv
// Ping-pong collector: packs 16 FIR samples per bank into one frame; fft_valid rises the cycle after the 16th sample.
// Valid/ready output holds while stalled; input drops samples (sticky overflow) when both banks are full. FIR_FRAME_BITREV_EN selects bit-reversed slots.
module fir_frame_collector #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fir_valid,
  input  logic [DATA_W-1:0]     fir_d,
  output logic                  fft_valid,
  input  logic                  fft_ready,
  output logic [16*DATA_W-1:0]  fft_d,
  output logic                  overflow
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_BOTH  = 2'd2;

  logic [16*DATA_W-1:0] r_bank [2];
  logic [1:0]           r_full;
  logic                 r_wr_sel;
  logic                 r_rd_sel;
  logic [3:0]           r_idx;
  logic [1:0]           r_state;
  logic                 r_fft_valid;
  logic                 r_overflow;

  logic                 w_accept;
  logic                 w_fill;
  logic                 w_xfer;
  logic [3:0]           w_slot;
  logic [1:0]           w_full_nxt;
  logic                 w_rd_sel_nxt;
  logic [1:0]           w_state_nxt;

`ifdef FIR_FRAME_BITREV_EN
  assign w_slot = {r_idx[0], r_idx[1], r_idx[2], r_idx[3]};
`else
  assign w_slot = r_idx;
`endif

  // Acceptance looks only at the registered flag, so a same-cycle transfer never frees space early.
  assign w_accept     = fir_valid && !r_full[r_wr_sel];
  assign w_fill       = w_accept && (r_idx == 4'd15);
  assign w_xfer       = r_fft_valid && fft_ready;
  assign w_rd_sel_nxt = r_rd_sel ^ w_xfer;

  always_comb begin
    w_full_nxt = r_full;
    if (w_fill) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_xfer) w_full_nxt[r_rd_sel] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case ({w_fill, w_xfer})
      2'b10: w_state_nxt = (r_state == ST_EMPTY) ? ST_ONE : ST_BOTH;
      2'b01: w_state_nxt = (r_state == ST_BOTH) ? ST_ONE : ST_EMPTY;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= 2'b00;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_idx       <= 4'd0;
      r_state     <= ST_EMPTY;
      r_fft_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_rd_sel    <= w_rd_sel_nxt;
      r_state     <= w_state_nxt;
      // Next-cycle valid follows the bank that will be selected, so a waiting full bank leaves no bubble.
      r_fft_valid <= w_full_nxt[w_rd_sel_nxt];
      if (w_accept) r_idx <= r_idx + 4'd1;
      if (w_fill) r_wr_sel <= ~r_wr_sel;
      if (fir_valid && r_full[r_wr_sel]) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_bank[r_wr_sel][DATA_W*w_slot +: DATA_W] <= fir_d;
  end

  assign fft_valid = r_fft_valid;
  assign fft_d     = r_bank[r_rd_sel];
  assign overflow  = r_overflow;

endmodule

// File: doc/fir_frame_collector.md
FIR_FRAME_COLLECTOR -- requirements
Module: fir_frame_collector

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the sample width in bits; the frame length SHALL be fixed at 16 samples.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port fir_valid, input, 1 bit: fir_d holds a sample this cycle.
REQ-005 The block SHALL have port fir_d, input, DATA_W bits: signed two's-complement filtered sample.
REQ-006 The block SHALL have port fft_valid, output, 1 bit: a complete frame is presented on fft_d.
REQ-007 The block SHALL have port fft_ready, input, 1 bit: the downstream consumer accepts the presented frame.
REQ-008 The block SHALL have port fft_d, output, 16*DATA_W bits: the frame, with slot j at bits [DATA_W*j+DATA_W-1 : DATA_W*j].
REQ-009 The block SHALL have port overflow, output, 1 bit: sticky flag meaning at least one sample was dropped.

Function
REQ-010 Storage SHALL be two ping-pong banks (A, B) of 16 samples each, with a full flag per bank, a write-bank select, a read-bank select and a 4-bit write index.
REQ-011 A sample SHALL be accepted when fir_valid=1 and the write bank is not full; it SHALL be written to slot map(idx) of the write bank, and idx SHALL then increment, wrapping 15->0.
REQ-012 On accepting the sample at idx=15, the write bank SHALL be marked full and the write-bank select SHALL toggle in the same edge.
REQ-013 Occupancy FSM states SHALL be EMPTY (0 banks full), ONE (1 full) and BOTH (2 full), with these transitions:
- fill only: +1
- transfer only: -1
- fill and transfer in the same cycle: unchanged
REQ-014 fft_valid SHALL be registered and equal 1 exactly when the read bank is full; fft_d SHALL be driven from the read bank.
REQ-015 Latency: fft_valid SHALL rise on the edge that accepts the 16th sample, i.e. it is visible in the following cycle.
REQ-016 A transfer SHALL occur when fft_valid and fft_ready are both 1; it SHALL clear the read bank's full flag and toggle the read-bank select.
REQ-017 While fft_valid=1 and fft_ready=0, fft_valid and fft_d SHALL hold stable.
REQ-018 When the other bank is already full at a transfer, fft_valid SHALL remain 1 and fft_d SHALL switch to that bank on the next cycle, with no bubble.
REQ-019 If fir_valid=1 while the write bank is full (state BOTH without a same-cycle transfer), the sample SHALL be dropped, idx SHALL not advance, and overflow SHALL be set to 1 until reset.
REQ-020 A sample arriving in the same cycle as a transfer that frees the write bank SHALL still be dropped; acceptance SHALL use the registered full flag only.
REQ-021 When fir_valid=0 mid-frame, a partial frame SHALL be retained, and collection SHALL resume at the current idx.
REQ-022 fir_valid=1 with fft_ready held 1 SHALL sustain one frame per 16 cycles with no drops.

Reset
REQ-023 rst=1 SHALL set fft_valid=0, overflow=0, both full flags=0, idx=0, and both the write-bank and read-bank selects to A on the next edge.
REQ-024 Reset SHALL discard any partial or pending frame, including one asserted mid-handshake.
REQ-025 Sample storage contents need not be reset; fft_d SHALL be don't-care while fft_valid=0.
REQ-026 rst SHALL take priority over fir_valid and fft_ready in the same cycle.

Configuration
REQ-027 With macro FIR_FRAME_BITREV_EN defined, map(idx) SHALL be the 4-bit bit-reversal of idx (e.g. 1->8, 3->12), so frames are emitted in FFT bit-reversed input order.
REQ-028 Without FIR_FRAME_BITREV_EN, map(idx) SHALL equal idx (natural order); all other behaviour SHALL be identical in both builds.

Verification
REQ-029 The bench SHALL cover natural-order fill:
- stimulus: reset, fft_ready=1, fir_d=0..15 on 16 consecutive cycles
- response: fft_valid=1 for exactly one cycle, one cycle after the last sample; fft_d slot j = j
REQ-030 The bench SHALL cover the bit-reversed build:
- stimulus: FIR_FRAME_BITREV_EN defined, same input as REQ-029
- response: slot 8 = 1, slot 12 = 3, slot 15 = 15
REQ-031 The bench SHALL cover backpressure:
- stimulus: fft_ready=0, 32 samples 0..31
- response: fft_valid stays 1 with fft_d slots 0..15; after one fft_ready pulse, next cycle fft_d slots = 16..31; overflow=0
REQ-032 The bench SHALL cover overflow:
- stimulus: fft_ready=0, 33 samples
- response: overflow=1 after the 33rd; sample 32 absent from all later frames
REQ-033 The bench SHALL cover mid-frame gap:
- stimulus: samples 0..7, fir_valid=0 for 5 cycles, then samples 8..15
- response: one frame with slots 0..15 in order
REQ-034 The bench SHALL cover reset mid-operation:
- stimulus: rst=1 after 10 samples, then 16 samples of value 100
- response: first frame is all 100; overflow=0
